// File: rtl/tile_board_ctrl.sv
// tile_board_ctrl: falling-tile game board, four 8-block columns stepped every STEP_CYCLES clocks.
// Optional macro TILE_MISS_OVER_EN: a key press on an empty column bottom ends the game.
module tile_board_ctrl #(
   parameter int unsigned STEP_CYCLES = 25_000_000,
   parameter logic [2:0]  TILE_CODE   = 3'b001
)(
   input  logic        CLK_50M,
   input  logic        RST,
   input  logic        start,
   input  logic [3:0]  key_hit,
   input  logic [1:0]  spawn_col,
   output logic [23:0] column_0,
   output logic [23:0] column_1,
   output logic [23:0] column_2,
   output logic [23:0] column_3,
   output logic [7:0]  score,
   output logic        running,
   output logic        game_over
);
   typedef enum logic [1:0] {IDLE, CLEAR, RUN, OVER} state_t;
   localparam logic [31:0] LAST = 32'(STEP_CYCLES - 1);
   state_t      state;
   logic [31:0] cnt;
   logic [23:0] col [4];
   logic [23:0] col_nxt [4];
   logic [3:0]  live, hit;
   logic        step, fail;
   logic [8:0]  sum;
   assign column_0 = col[0];
   assign column_1 = col[1];
   assign column_2 = col[2];
   assign column_3 = col[3];
   // a stepping column drops its bottom block anyway, so a hit only matters off-step
   always_comb begin
      step = cnt == LAST;
      for (int c = 0; c < 4; c++) begin
         live[c]    = col[c][2:0] != 3'b000;
         hit[c]     = key_hit[c] & live[c];
         col_nxt[c] = step ? {(spawn_col == 2'(c)) ? TILE_CODE : 3'b000, col[c][23:3]}
                    : hit[c] ? {col[c][23:3], 3'b000} : col[c];
      end
      sum = 9'(score) + 9'(hit[0]) + 9'(hit[1]) + 9'(hit[2]) + 9'(hit[3]);
`ifdef TILE_MISS_OVER_EN
      fail = (step && |(live & ~key_hit)) || |(key_hit & ~live);
`else
      fail = step && |(live & ~key_hit);
`endif
   end
   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         col       <= '{default: '0};
         score     <= '0;
         running   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) state <= CLEAR;
            CLEAR: begin
               col     <= '{default: '0};
               score   <= '0;
               cnt     <= '0;
               running <= 1'b1;
               state   <= RUN;
            end
            RUN: begin
               cnt   <= step ? '0 : cnt + 32'd1;
               col   <= col_nxt;
               score <= sum[8] ? 8'hFF : sum[7:0];
               if (fail) begin
                  state     <= OVER;
                  running   <= 1'b0;
                  game_over <= 1'b1;
               end
            end
            OVER: if (start) begin
               state     <= CLEAR;
               game_over <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tile_board_ctrl.sv
// tb_tile_board_ctrl: random and directed play against a block-level board model.
module tb_tile_board_ctrl;
   logic        CLK_50M = 1'b0;
   logic        RST = 1'b1, start = 1'b0;
   logic [3:0]  key_hit = '0;
   logic [1:0]  spawn_col = '0;
   logic [23:0] column_0, column_1, column_2, column_3;
   logic [7:0]  score;
   logic        running, game_over;
   int checks = 0, errors = 0;
   int m_b [4][8];
   int m_score = 0, m_mode = 0, m_ph = 0;

   tile_board_ctrl #(.STEP_CYCLES(4), .TILE_CODE(3'b001)) dut (
      .CLK_50M(CLK_50M), .RST(RST), .start(start), .key_hit(key_hit), .spawn_col(spawn_col),
      .column_0(column_0), .column_1(column_1), .column_2(column_2), .column_3(column_3),
      .score(score), .running(running), .game_over(game_over));

   always #5 CLK_50M = ~CLK_50M;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] pack(input int c);
      logic [23:0] v = '0;
      for (int k = 0; k < 8; k++) v[23 - 3*k -: 3] = 3'(m_b[c][k]);
      return v;
   endfunction

   task automatic wipe();
      for (int c = 0; c < 4; c++) for (int k = 0; k < 8; k++) m_b[c][k] = 0;
   endtask

   // mode: 0 idle, 1 clear, 2 run, 3 over
   task automatic model(input logic r, input logic s, input logic [3:0] key, input logic [1:0] sp);
      bit st, lost;
      if (r) begin
         wipe(); m_score = 0; m_ph = 0; m_mode = 0;
         return;
      end
      case (m_mode)
         0: if (s) m_mode = 1;
         1: begin wipe(); m_score = 0; m_ph = 0; m_mode = 2; end
         2: begin
            st = m_ph == 3;
            m_ph = st ? 0 : m_ph + 1;
            lost = 0;
            for (int c = 0; c < 4; c++) if (key[c]) begin
               if (m_b[c][7] != 0) begin
                  m_b[c][7] = 0;
                  if (m_score < 255) m_score++;
               end
`ifdef TILE_MISS_OVER_EN
               else lost = 1;
`endif
            end
            if (st) for (int c = 0; c < 4; c++) begin
               if (m_b[c][7] != 0) lost = 1;
               for (int k = 7; k > 0; k--) m_b[c][k] = m_b[c][k-1];
               m_b[c][0] = (c == int'(sp)) ? 1 : 0;
            end
            if (lost) m_mode = 3;
         end
         default: if (s) m_mode = 1;
      endcase
   endtask

   task automatic cycle(input logic r, input logic s, input logic [3:0] key, input logic [1:0] sp);
      RST = r; start = s; key_hit = key; spawn_col = sp;
      model(r, s, key, sp);
      @(posedge CLK_50M); #1;
      check("column_0", 32'(column_0), 32'(pack(0)));
      check("column_1", 32'(column_1), 32'(pack(1)));
      check("column_2", 32'(column_2), 32'(pack(2)));
      check("column_3", 32'(column_3), 32'(pack(3)));
      check("score", 32'(score), 32'(m_score));
      check("running", 32'(running), 32'(m_mode == 2));
      check("game_over", 32'(game_over), 32'(m_mode == 3));
   endtask

   function automatic logic [3:0] perfect();
      logic [3:0] k = '0;
      for (int c = 0; c < 4; c++) k[c] = (m_mode == 2) && (m_b[c][7] != 0);
      return k;
   endfunction

   initial begin
      wipe();
      #1;
      cycle(1, 0, 4'h0, 2'd0);
      check("rst_score", 32'(score), 0);
      cycle(0, 1, 4'h0, 2'd2);
      cycle(0, 0, 4'h0, 2'd2);
      check("run_flag", 32'(running), 1);
      repeat (4) cycle(0, 0, 4'h0, 2'd2);
      check("first_spawn", 32'(column_2), 32'h200000);
      repeat (28) cycle(0, 0, 4'h0, 2'd2);
      check("full_column", 32'(column_2), 32'h249249);
      repeat (3) cycle(0, 0, 4'h0, 2'd2);
      cycle(0, 0, 4'b0100, 2'd2);
      check("hit_on_step_score", 32'(score), 1);
      check("hit_on_step_over", 32'(game_over), 0);
      check("hit_on_step_col", 32'(column_2), 32'h249249);
      repeat (4) cycle(0, 0, 4'h0, 2'd2);
      check("missed_tile_over", 32'(game_over), 1);
      repeat (3) cycle(0, 0, 4'hF, 2'd1);
      check("frozen_col", 32'(column_2), 32'h249249);
      cycle(0, 1, 4'h0, 2'd0);
      cycle(0, 0, 4'h0, 2'd0);
      check("restart_score", 32'(score), 0);
      repeat (1200) cycle(0, 0, perfect(), 2'($urandom_range(0, 3)));
      check("saturated", 32'(score), 255);
      cycle(0, 0, perfect() | 4'b0001, 2'd0);
      check("saturated_hold", 32'(score), 255);
      cycle(1, 1, 4'hF, 2'd3);
      check("rst_mid_run", 32'({column_0, score, running, game_over}), 0);
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] key;
         key = $urandom_range(0, 1) ? perfect() : 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0, key, 2'($urandom_range(0, 3)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
